// File: rtl/ddr_global_pkg.sv
// Shared types for the DDR debug path: snoop capture sequencer states and
// the per-state control word that the sequencer registers onto its outputs.
package ddr_global_pkg;

  localparam int SNOOP_CTRL_SWIDTH = 3;

  typedef enum logic [SNOOP_CTRL_SWIDTH-1:0] {
    SNOOP_IDLE      = 3'd0,
    SNOOP_CLEAR     = 3'd1,
    SNOOP_WAIT_TRIG = 3'd2,
    SNOOP_CAPTURE   = 3'd3,
    SNOOP_DONE      = 3'd4
  } ddr_snoop_ctrl_state_t;

  typedef struct packed {
    logic snoop_mode;
    logic ts_reset;
    logic ts_enable;
    logic pattern_0_en;
    logic pattern_1_en;
    logic eg_rdata_clr;
    logic busy;
    logic done;
  } ddr_snoop_ctl_t;

  // Control word owned by a state; registered together with the state itself.
  function automatic ddr_snoop_ctl_t snoop_ctl_of(input ddr_snoop_ctrl_state_t s);
    ddr_snoop_ctl_t c;
    c = '0;
    case (s)
      SNOOP_CLEAR: begin
        c.snoop_mode   = 1'b1;
        c.ts_reset     = 1'b1;
        c.eg_rdata_clr = 1'b1;
        c.busy         = 1'b1;
      end
      SNOOP_WAIT_TRIG: begin
        c.snoop_mode   = 1'b1;
        c.ts_enable    = 1'b1;
        c.pattern_0_en = 1'b1;
        c.busy         = 1'b1;
      end
      SNOOP_CAPTURE: begin
        c.snoop_mode   = 1'b1;
        c.ts_enable    = 1'b1;
        c.pattern_0_en = 1'b1;
        c.pattern_1_en = 1'b1;
        c.busy         = 1'b1;
      end
      SNOOP_DONE: begin
        c.snoop_mode = 1'b1;
        c.done       = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ddr_demet_r.sv
// Two-flop synchroniser with asynchronous active-high reset.
module ddr_demet_r (
  input  logic clk_g,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage resynchronisation of the incoming level.
  always_ff @(posedge clk_g or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ddr_tgl_pulse.sv
// Converts a CSR toggle from another domain into a one-cycle pulse on clk_g.
module ddr_tgl_pulse (
  input  logic clk_g,
  input  logic i_rst,
  input  logic i_tgl,
  output logic o_pulse
);

  logic w_sync;
  logic r_prev;

  ddr_demet_r u_demet (
    .clk_g (clk_g),
    .i_rst (i_rst),
    .i_d   (i_tgl),
    .o_q   (w_sync)
  );

  // Delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk_g or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_sync;
    end
  end

  assign o_pulse = w_sync ^ r_prev;

endmodule

// File: rtl/ddr_snoop_ctrl.sv
// Capture sequencer for one snoop instance: clear, arm on trigger, capture N events.
// Optional WAIT_TRIG timeout is built when DDR_SNOOP_CTRL_TIMEOUT_EN is defined.
module ddr_snoop_ctrl
  import ddr_global_pkg::*;
#(
  parameter int CWIDTH  = 16,
  parameter int TOWIDTH = 24,
  parameter int CLR_CYC = 4
) (
  input  logic                         clk_g,
  input  logic                         i_rst,
  input  logic                         i_start_tgl,
  input  logic                         i_abort_tgl,
  input  logic                         i_ack_tgl,
  input  logic [CWIDTH-1:0]            i_post_cnt,
  input  logic [TOWIDTH-1:0]           i_timeout,
  input  logic                         i_trig,
  input  logic                         i_event,
  input  logic                         i_eg_full,
  output logic                         o_snoop_mode,
  output logic                         o_ts_reset,
  output logic                         o_ts_enable,
  output logic                         o_pattern_0_en,
  output logic                         o_pattern_1_en,
  output logic                         o_eg_rdata_clr,
  output logic [SNOOP_CTRL_SWIDTH-1:0] o_state,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [CWIDTH-1:0]            o_evt_cnt,
  output logic                         o_overflow,
  output logic                         o_timeout
);

  localparam int CLRW = $clog2(CLR_CYC + 1);
  localparam logic [CLRW-1:0] CLR_LAST = CLRW'(CLR_CYC - 1);

  logic w_start;
  logic w_abort;
  logic w_ack;
  logic w_to_hit;

  ddr_snoop_ctrl_state_t r_state;
  ddr_snoop_ctl_t        r_ctl;
  logic [CLRW-1:0]       r_clr_cnt;
  logic [CWIDTH-1:0]     r_remain;
  logic [CWIDTH-1:0]     r_evt_cnt;
  logic                  r_overflow;
  logic                  r_timeout;

  ddr_tgl_pulse u_start (.clk_g(clk_g), .i_rst(i_rst), .i_tgl(i_start_tgl), .o_pulse(w_start));
  ddr_tgl_pulse u_abort (.clk_g(clk_g), .i_rst(i_rst), .i_tgl(i_abort_tgl), .o_pulse(w_abort));
  ddr_tgl_pulse u_ack   (.clk_g(clk_g), .i_rst(i_rst), .i_tgl(i_ack_tgl),   .o_pulse(w_ack));

`ifdef DDR_SNOOP_CTRL_TIMEOUT_EN
  logic [TOWIDTH-1:0] r_to_cnt;
  logic [TOWIDTH-1:0] w_to_next;

  assign w_to_next = r_to_cnt + TOWIDTH'(1);
  // Hit on the cycle that completes i_timeout cycles spent in WAIT_TRIG.
  assign w_to_hit  = (i_timeout != '0) && (w_to_next == i_timeout);

  // Cycles spent in WAIT_TRIG; idles at zero elsewhere.
  always_ff @(posedge clk_g or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (r_state == SNOOP_WAIT_TRIG) begin
      r_to_cnt <= w_to_next;
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^i_timeout;
  assign w_to_hit         = 1'b0;
`endif

  // Sequencer: state, registered control word, event counters and sticky flags.
  always_ff @(posedge clk_g or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= SNOOP_IDLE;
      r_ctl      <= '0;
      r_clr_cnt  <= '0;
      r_remain   <= '0;
      r_evt_cnt  <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_abort) begin
      r_state <= SNOOP_IDLE;
      r_ctl   <= snoop_ctl_of(SNOOP_IDLE);
    end else begin
      case (r_state)
        SNOOP_IDLE: begin
          if (w_start) begin
            r_state    <= SNOOP_CLEAR;
            r_ctl      <= snoop_ctl_of(SNOOP_CLEAR);
            r_clr_cnt  <= '0;
            r_evt_cnt  <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        SNOOP_CLEAR: begin
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= SNOOP_WAIT_TRIG;
            r_ctl   <= snoop_ctl_of(SNOOP_WAIT_TRIG);
          end else begin
            r_clr_cnt <= r_clr_cnt + CLRW'(1);
          end
        end
        SNOOP_WAIT_TRIG: begin
          if (i_trig) begin
            if (i_post_cnt == '0) begin
              r_state <= SNOOP_DONE;
              r_ctl   <= snoop_ctl_of(SNOOP_DONE);
            end else begin
              r_state  <= SNOOP_CAPTURE;
              r_ctl    <= snoop_ctl_of(SNOOP_CAPTURE);
              r_remain <= i_post_cnt;
            end
          end else if (w_to_hit) begin
            r_state   <= SNOOP_DONE;
            r_ctl     <= snoop_ctl_of(SNOOP_DONE);
            r_timeout <= 1'b1;
          end
        end
        SNOOP_CAPTURE: begin
          if (i_event) begin
            if (r_evt_cnt != '1) begin
              r_evt_cnt <= r_evt_cnt + CWIDTH'(1);
            end
            r_remain <= r_remain - CWIDTH'(1);
          end
          if (i_eg_full) begin
            r_overflow <= 1'b1;
          end
          if (i_eg_full || (i_event && (r_remain == CWIDTH'(1)))) begin
            r_state <= SNOOP_DONE;
            r_ctl   <= snoop_ctl_of(SNOOP_DONE);
          end
        end
        SNOOP_DONE: begin
          if (w_start) begin
            r_state    <= SNOOP_CLEAR;
            r_ctl      <= snoop_ctl_of(SNOOP_CLEAR);
            r_clr_cnt  <= '0;
            r_evt_cnt  <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
          end else if (w_ack) begin
            r_state <= SNOOP_IDLE;
            r_ctl   <= snoop_ctl_of(SNOOP_IDLE);
          end
        end
        default: begin
          r_state <= SNOOP_IDLE;
          r_ctl   <= snoop_ctl_of(SNOOP_IDLE);
        end
      endcase
    end
  end

  assign o_state        = r_state;
  assign o_snoop_mode   = r_ctl.snoop_mode;
  assign o_ts_reset     = r_ctl.ts_reset;
  assign o_ts_enable    = r_ctl.ts_enable;
  assign o_pattern_0_en = r_ctl.pattern_0_en;
  assign o_pattern_1_en = r_ctl.pattern_1_en;
  assign o_eg_rdata_clr = r_ctl.eg_rdata_clr;
  assign o_busy         = r_ctl.busy;
  assign o_done         = r_ctl.done;
  assign o_evt_cnt      = r_evt_cnt;
  assign o_overflow     = r_overflow;
  assign o_timeout      = r_timeout;

endmodule
